// File: rtl/uart_pkg.sv
// Shared types and helpers for the buffered UART transmitter.
// The parity helper works on a zero-extended byte, so narrower payloads are handled too.
package uart_pkg;

  typedef enum logic [1:0] {
    PAR_NONE,
    PAR_EVEN,
    PAR_ODD
  } parity_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } tx_state_t;

  // Even parity makes the total count of ones even; odd parity inverts it.
  function automatic logic parity_bit(input logic [7:0] data, input parity_t mode);
    logic p;
    p = ^data;
    return (mode == PAR_ODD) ? ~p : p;
  endfunction

endpackage

// File: rtl/uart_tx_fifo_sync_fifo.sv
// Single-clock first-word-fall-through FIFO with registered full/empty flags.
// rd_data always shows the head entry, so a pop strobe consumes the word on the same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count_nxt;
  logic             push;
  logic             pop;

  assign push    = wr_en && !full;
  assign pop     = rd_en && !empty;
  assign rd_data = mem[rd_ptr];

  always_comb begin
    count_nxt = count;
    if (push && !pop)
      count_nxt = count + 1'b1;
    else if (!push && pop)
      count_nxt = count - 1'b1;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      count <= count_nxt;
      full  <= (count_nxt == FULL_COUNT);
      empty <= (count_nxt == '0);
    end
  end

  always_ff @(posedge CLK) begin
    if (push)
      mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: FIFO-fed serialiser producing back-to-back frames.
// The line flop follows the FSM state one cycle later, so it never glitches.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int      CLKS_PER_BIT = 2604,
  parameter int      DATA_BITS    = 8,
  parameter parity_t PARITY       = PAR_NONE,
  parameter int      STOP_BITS    = 1,
  parameter int      FIFO_DEPTH   = 16
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic [DATA_BITS-1:0]          data_in,
  input  logic                          valid_in,
  output logic                          ready_out,
  output logic                          UART_TX,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int          CW        = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]  DATA_LAST = 3'(DATA_BITS - 1);
  localparam logic [2:0]  STOP_LAST = 3'(STOP_BITS - 1);

  tx_state_t            state;
  logic [CW-1:0]        baud_cnt;
  logic [2:0]           bit_idx;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_q;
  logic                 tx_q;

  logic                 fifo_full;
  logic                 fifo_empty;
  logic [DATA_BITS-1:0] fifo_rd_data;
  logic                 baud_end;
  logic                 stop_done;
  logic                 pop;

  sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .CLK     (CLK),
    .RST     (RST),
    .wr_en   (valid_in),
    .wr_data (data_in),
    .rd_en   (pop),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  assign baud_end  = (baud_cnt == BAUD_LAST);
  assign stop_done = (state == S_STOP) && baud_end && (bit_idx == STOP_LAST);
  // Popping on the last stop cycle chains the next frame with no idle gap.
  assign pop       = !fifo_empty && ((state == S_IDLE) || stop_done);

  assign ready_out = !fifo_full;
  assign UART_TX   = tx_q;
  assign busy      = (state != S_IDLE) || !fifo_empty;

  always_ff @(posedge CLK) begin
    if (pop) begin
      shreg <= fifo_rd_data;
      par_q <= parity_bit(8'(fifo_rd_data), PARITY);
    end else if ((state == S_DATA) && baud_end) begin
      shreg <= shreg >> 1;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state    <= S_IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      tx_q     <= 1'b1;
    end else begin
      baud_cnt <= baud_end ? '0 : baud_cnt + 1'b1;

      unique case (state)
        S_IDLE:   tx_q <= 1'b1;
        S_START:  tx_q <= 1'b0;
        S_DATA:   tx_q <= shreg[0];
        S_PARITY: tx_q <= par_q;
        S_STOP:   tx_q <= 1'b1;
        default:  tx_q <= 1'b1;
      endcase

      unique case (state)
        S_IDLE: begin
          baud_cnt <= '0;
          bit_idx  <= '0;
          if (!fifo_empty)
            state <= S_START;
        end
        S_START: begin
          if (baud_end) begin
            state   <= S_DATA;
            bit_idx <= '0;
          end
        end
        S_DATA: begin
          if (baud_end) begin
            if (bit_idx == DATA_LAST) begin
              state   <= (PARITY != PAR_NONE) ? S_PARITY : S_STOP;
              bit_idx <= '0;
            end else begin
              bit_idx <= bit_idx + 1'b1;
            end
          end
        end
        S_PARITY: begin
          if (baud_end) begin
            state   <= S_STOP;
            bit_idx <= '0;
          end
        end
        S_STOP: begin
          if (baud_end) begin
            if (bit_idx == STOP_LAST) begin
              state   <= fifo_empty ? S_IDLE : S_START;
              bit_idx <= '0;
            end else begin
              bit_idx <= bit_idx + 1'b1;
            end
          end
        end
        default: begin
          state    <= S_IDLE;
          baud_cnt <= '0;
          bit_idx  <= '0;
        end
      endcase
    end
  end

endmodule
